// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between two requesters with round-robin arbitration.
// One operation is in flight at a time; operands and result are registered.
module alu_share_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_rs1,
    input  logic [31:0]      req0_rs2,
    input  logic [3:0]       req0_sel,
    input  logic [31:0]      req1_rs1,
    input  logic [31:0]      req1_rs2,
    input  logic [3:0]       req1_sel,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [31:0]      resp_data,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    output logic [3:0]       alu_sel,
    input  logic [31:0]      alu_res,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic [1:0]       r_resp_valid;
    logic [31:0]      r_resp_data;
    logic [31:0]      r_alu_rs1;
    logic [31:0]      r_alu_rs2;
    logic [3:0]       r_alu_sel;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic             w_winner;
    logic [1:0]       w_grant;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Round-robin winner: on a tie the port that did not win last time goes.
    always_comb begin
        w_winner = 1'b0;
        if (req_valid == 2'b11) begin
            w_winner = ~r_last_grant;
        end else if (req_valid[1]) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
    end

    // Accept strobe, only ever offered while idle.
    always_comb begin
        w_grant = 2'b00;
        if ((r_state == S_IDLE) && (req_valid != 2'b00)) begin
            w_grant = w_winner ? 2'b10 : 2'b01;
        end else begin
            w_grant = 2'b00;
        end
    end

    // Sequencer: accept in IDLE, sample the ALU in EXEC, hold the result in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_resp_valid <= 2'b00;
            r_resp_data  <= 32'd0;
            r_alu_rs1    <= 32'd0;
            r_alu_rs2    <= 32'd0;
            r_alu_sel    <= 4'd0;
            r_busy       <= 1'b0;
            r_cnt0       <= {CNT_W{1'b0}};
            r_cnt1       <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_alu_rs1    <= w_winner ? req1_rs1 : req0_rs1;
                        r_alu_rs2    <= w_winner ? req1_rs2 : req0_rs2;
                        r_alu_sel    <= w_winner ? req1_sel : req0_sel;
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_busy       <= 1'b1;
                        r_state      <= S_EXEC;
                        if (w_winner) begin
                            r_cnt1 <= sat_inc(r_cnt1);
                        end else begin
                            r_cnt0 <= sat_inc(r_cnt0);
                        end
                    end
                end
                S_EXEC: begin
                    r_resp_data  <= alu_res;
                    r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    // Only the owning port's ready can retire the response.
                    if (resp_ready[r_owner]) begin
                        r_resp_valid <= 2'b00;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 2'b00;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign alu_rs1    = r_alu_rs1;
    assign alu_rs2    = r_alu_rs2;
    assign alu_sel    = r_alu_sel;
    assign busy       = r_busy;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed vectors push expected responses,
// a monitor pops and compares on every response handshake.
module tb_alu_share_arbiter;

    localparam logic [3:0] SEL_ADD = 4'd0;
    localparam logic [3:0] SEL_SUB = 4'd1;

    typedef struct packed {
        logic [1:0]  vld;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  sel;
        logic [31:0] res;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [3:0]  req0_sel, req1_sel, alu_sel;
    logic [31:0] resp_data, alu_rs1, alu_rs2, alu_res;
    logic        busy;
    logic [15:0] grant_cnt0, grant_cnt1;

    // Small-counter instance used to reach saturation quickly
    logic [1:0]  s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
    logic [31:0] s_resp_data, s_alu_rs1, s_alu_rs2, s_alu_res;
    logic [3:0]  s_alu_sel;
    logic        s_busy;
    logic [2:0]  s_grant_cnt0, s_grant_cnt1;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t p0v[2];
    vec_t p1v[2];

    always #5 clk = ~clk;

    always_comb begin
        case (alu_sel)
            SEL_SUB: alu_res = alu_rs1 - alu_rs2;
            default: alu_res = alu_rs1 + alu_rs2;
        endcase
    end
    assign s_alu_res = s_alu_rs1 ^ s_alu_rs2;

    alu_share_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_sel(req0_sel),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_sel(req1_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_sel(alu_sel), .alu_res(alu_res),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_share_arbiter #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req0_rs1(32'd3), .req0_rs2(32'd5), .req0_sel(SEL_ADD),
        .req1_rs1(32'd0), .req1_rs2(32'd0), .req1_sel(SEL_ADD),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_data(s_resp_data),
        .alu_rs1(s_alu_rs1), .alu_rs2(s_alu_rs2), .alu_sel(s_alu_sel), .alu_res(s_alu_res),
        .busy(s_busy), .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ((resp_valid & resp_ready) != 2'b00)) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", {62'd0, resp_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_owner", {62'd0, resp_valid}, {62'd0, e.vld});
                chk("resp_data", {32'd0, resp_data}, {32'd0, e.data});
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        s_req_valid = 2'b00;
        s_resp_ready = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_accept(input string name, input logic [1:0] exp);
        int n;
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, {62'd0, req_ready}, {62'd0, exp});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic load0(input vec_t v);
        req0_rs1 = v.rs1; req0_rs2 = v.rs2; req0_sel = v.sel;
    endtask

    task automatic load1(input vec_t v);
        req1_rs1 = v.rs1; req1_rs2 = v.rs2; req1_sel = v.sel;
    endtask

    initial begin
        int i0, i1, n;
        p0v[0] = '{rs1: 32'd100, rs2: 32'd23, sel: SEL_ADD, res: 32'd123};
        p0v[1] = '{rs1: 32'd50,  rs2: 32'd8,  sel: SEL_SUB, res: 32'd42};
        p1v[0] = '{rs1: 32'd7,   rs2: 32'd9,  sel: SEL_ADD, res: 32'd16};
        p1v[1] = '{rs1: 32'd1,   rs2: 32'd2,  sel: SEL_SUB, res: 32'hFFFF_FFFF};
        req0_rs1 = 32'd0; req0_rs2 = 32'd0; req0_sel = 4'd0;
        req1_rs1 = 32'd0; req1_rs2 = 32'd0; req1_sel = 4'd0;

        // Reset state
        do_reset();
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
        chk("rst_alu_rs1", {32'd0, alu_rs1}, 64'd0);
        chk("rst_alu_rs2", {32'd0, alu_rs2}, 64'd0);
        chk("rst_alu_sel", {60'd0, alu_sel}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cnt0", {48'd0, grant_cnt0}, 64'd0);
        chk("rst_cnt1", {48'd0, grant_cnt1}, 64'd0);

        // 1: single port-0 ADD 5+7
        resp_ready = 2'b01;
        req0_rs1 = 32'd5; req0_rs2 = 32'd7; req0_sel = SEL_ADD;
        req_valid = 2'b01;
        sb_q.push_back(exp_t'({2'b01, 32'd12}));
        wait_accept("t1_ready", 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_cnt0", {48'd0, grant_cnt0}, 64'd1);
        chk("t1_alu_rs1", {32'd0, alu_rs1}, 64'd5);
        @(posedge clk); #1;
        chk("t1_resp_valid", {62'd0, resp_valid}, 64'd1);
        chk("t1_resp_data", {32'd0, resp_data}, 64'd12);
        wait_idle("t1_idle");

        // 2: both ports valid, round-robin alternation 0,1,0,1
        do_reset();
        resp_ready = 2'b11;
        load0(p0v[0]); load1(p1v[0]);
        i0 = 0; i1 = 0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                sb_q.push_back(exp_t'({2'b01, p0v[i0].res}));
                wait_accept("t2_grant0", 2'b01);
                @(posedge clk); #1;
                i0++;
                if (i0 < 2) load0(p0v[i0]);
            end else begin
                sb_q.push_back(exp_t'({2'b10, p1v[i1].res}));
                wait_accept("t2_grant1", 2'b10);
                @(posedge clk); #1;
                i1++;
                if (i1 < 2) load1(p1v[i1]);
            end
            if (k == 3) req_valid = 2'b00;
        end
        wait_idle("t2_idle");
        chk("t2_cnt0", {48'd0, grant_cnt0}, 64'd2);
        chk("t2_cnt1", {48'd0, grant_cnt1}, 64'd2);
        chk("t2_sb_drained", sb_q.size(), 64'd0);

        // 3: port-1 SUB 3-10 held while owner not ready; port 0 blocked
        do_reset();
        resp_ready = 2'b01;
        req1_rs1 = 32'd3; req1_rs2 = 32'd10; req1_sel = SEL_SUB;
        req_valid = 2'b10;
        sb_q.push_back(exp_t'({2'b10, 32'hFFFF_FFF9}));
        wait_accept("t3_ready", 2'b10);
        @(posedge clk); #1 req_valid = 2'b01;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", {62'd0, resp_valid}, 64'd2);
            chk("t3_hold_data", {32'd0, resp_data}, 64'hFFFF_FFF9);
            chk("t3_p0_blocked", {62'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        resp_ready = 2'b10;
        @(posedge clk); #1;
        chk("t3_idle", {63'd0, busy}, 64'd0);
        chk("t3_cnt0", {48'd0, grant_cnt0}, 64'd0);
        chk("t3_cnt1", {48'd0, grant_cnt1}, 64'd1);

        // 4: reset during EXEC abandons the op
        do_reset();
        resp_ready = 2'b11;
        req0_rs1 = 32'd1; req0_rs2 = 32'd2; req0_sel = SEL_ADD;
        req_valid = 2'b01;
        wait_accept("t4_accept", 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("t4_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("t4_resp_data", {32'd0, resp_data}, 64'd0);
        chk("t4_alu_rs1", {32'd0, alu_rs1}, 64'd0);
        chk("t4_alu_rs2", {32'd0, alu_rs2}, 64'd0);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_cnt0", {48'd0, grant_cnt0}, 64'd0);
        @(posedge clk); #1;
        chk("t4_no_resp", {62'd0, resp_valid}, 64'd0);
        req0_rs1 = 32'd20; req0_rs2 = 32'd22; req0_sel = SEL_ADD;
        req1_rs1 = 32'd9;  req1_rs2 = 32'd4;  req1_sel = SEL_SUB;
        req_valid = 2'b11;
        sb_q.push_back(exp_t'({2'b01, 32'd42}));
        wait_accept("t4_tie", 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle("t4_idle");

        // 5: grant counter saturation (3-bit counter instance)
        do_reset();
        s_resp_ready = 2'b01;
        s_req_valid = 2'b01;
        #1;
        for (int i = 1; i <= 10; i++) begin
            n = 0;
            while (s_req_ready != 2'b01 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t5_ready", {62'd0, s_req_ready}, 64'd1);
            @(posedge clk); #1;
            chk("t5_cnt0", {61'd0, s_grant_cnt0}, (i < 7) ? 64'(i) : 64'd7);
        end
        s_req_valid = 2'b00;
        chk("t5_cnt1", {61'd0, s_grant_cnt1}, 64'd0);

        // 6: request raised and withdrawn during RESP is never accepted
        do_reset();
        req0_rs1 = 32'd30; req0_rs2 = 32'd12; req0_sel = SEL_SUB;
        req_valid = 2'b01;
        sb_q.push_back(exp_t'({2'b01, 32'd18}));
        wait_accept("t6_accept", 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #1 req_valid = 2'b01;
        #1;
        chk("t6_no_accept", {62'd0, req_ready}, 64'd0);
        @(posedge clk); #1 req_valid = 2'b00;
        chk("t6_resp_held", {62'd0, resp_valid}, 64'd1);
        resp_ready = 2'b01;
        @(posedge clk); #1;
        chk("t6_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("t6_cnt0", {48'd0, grant_cnt0}, 64'd1);
        chk("t6_req_ready", {62'd0, req_ready}, 64'd0);

        chk("sb_empty", sb_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
